// File: rtl/bicubic_window_buffer_pkg.sv
// -----------------------------------------------------------------------------
// bicubic_window_buffer_pkg
//
// Shared constants and helpers for the bicubic 4x4 window buffer:
//   - FSM state encodings (FILL / PRIME / STREAM / ROW_END)
//   - line-ring geometry (5 line memories, 3-bit ring index)
//   - width helpers for the column/row counters ($clog2(W)+1, $clog2(H)+1)
//   - ring_add: modulo-5 step through the line ring
// No ports; imported by the top module and its line memory.
// -----------------------------------------------------------------------------
package bicubic_window_buffer_pkg;

   localparam logic [1:0] ST_FILL    = 2'd0;
   localparam logic [1:0] ST_PRIME   = 2'd1;
   localparam logic [1:0] ST_STREAM  = 2'd2;
   localparam logic [1:0] ST_ROW_END = 2'd3;

   localparam int NUM_LINES  = 5;
   localparam int LINE_IDX_W = 3;
   localparam int WIN_DIM    = 4;

   typedef logic [LINE_IDX_W-1:0] line_idx_t;

   // Column counter runs 0..W inclusive, hence one extra bit.
   function automatic int col_cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   // Row counters run 0..H inclusive (write side counts completed rows).
   function automatic int row_cnt_width(input int h);
      return $clog2(h) + 1;
   endfunction

   function automatic int addr_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   // base + off modulo NUM_LINES; off may be negative (down to -NUM_LINES).
   function automatic line_idx_t ring_add(input line_idx_t base, input int off);
      int t;
      t = int'(base) + off + NUM_LINES;
      t = t % NUM_LINES;
      return LINE_IDX_W'(t);
   endfunction

endpackage

// File: rtl/bicubic_line_mem.sv
// -----------------------------------------------------------------------------
// bicubic_line_mem
//
// One source line: DEPTH x DATA_W storage with one write port and one
// registered read port. rd_data updates only on rd_en and otherwise holds its
// last value, so the reader can treat it as a one-entry look-ahead register.
//
// Ports:
//   clk, rst_n           clock, async active-low reset (clears rd_data only)
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr        read request, data visible the following cycle
//   rd_data              registered read data
// -----------------------------------------------------------------------------
module bicubic_line_mem
   import bicubic_window_buffer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 960,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/bicubic_window_buffer.sv
// -----------------------------------------------------------------------------
// bicubic_window_buffer
//
// Buffers a raster source image in a ring of 5 line memories and emits 4x4
// pixel windows for a bicubic upsampler. For each window row k (0..H-1) it
// emits W+1 windows (j = 0..W) and replays that sequence 4 times in total.
// Window (k,j) element (r,c) is source pixel
//   (clamp(k-1+r, 0, H-1), clamp(j-2+c, 0, W-1)).
//
// Handshakes: both interfaces are valid/ready. A source pixel moves on a
// cycle with in_valid & in_ready; a window moves on a cycle with
// bf_req_valid & bcci_req_ready. Once bf_req_valid is high it, and p1..p16,
// hold until that transfer happens.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   source pixel handshake, in_data raster order
//   bf_req_valid        window valid to upsampler
//   bcci_req_ready      upsampler accepts window
//   p1..p16             window, p(4*r+c+1) = row r, column c
// -----------------------------------------------------------------------------
module bicubic_window_buffer
   import bicubic_window_buffer_pkg::*;
#(
   parameter int CHANNEL_WIDTH = 8,
   parameter int BLOCK_SIZE    = 960,
   parameter int IMG_HEIGHT    = 540
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CHANNEL_WIDTH-1:0] in_data,
   output logic                     bf_req_valid,
   input  logic                     bcci_req_ready,
   output logic [CHANNEL_WIDTH-1:0] p1,
   output logic [CHANNEL_WIDTH-1:0] p2,
   output logic [CHANNEL_WIDTH-1:0] p3,
   output logic [CHANNEL_WIDTH-1:0] p4,
   output logic [CHANNEL_WIDTH-1:0] p5,
   output logic [CHANNEL_WIDTH-1:0] p6,
   output logic [CHANNEL_WIDTH-1:0] p7,
   output logic [CHANNEL_WIDTH-1:0] p8,
   output logic [CHANNEL_WIDTH-1:0] p9,
   output logic [CHANNEL_WIDTH-1:0] p10,
   output logic [CHANNEL_WIDTH-1:0] p11,
   output logic [CHANNEL_WIDTH-1:0] p12,
   output logic [CHANNEL_WIDTH-1:0] p13,
   output logic [CHANNEL_WIDTH-1:0] p14,
   output logic [CHANNEL_WIDTH-1:0] p15,
   output logic [CHANNEL_WIDTH-1:0] p16
);

   localparam int W  = BLOCK_SIZE;
   localparam int H  = IMG_HEIGHT;
   localparam int PW = CHANNEL_WIDTH;
   localparam int CW = col_cnt_width(W);
   localparam int RW = row_cnt_width(H);
   localparam int AW = addr_width(W);

   // ---------------------------------------------------------------- helpers
   function automatic logic [AW-1:0] clamp_col(input int v);
      int t;
      t = v;
      if (t < 0) t = 0;
      if (t > W - 1) t = W - 1;
      return AW'(t);
   endfunction

   function automatic int clamp_row(input int v);
      int t;
      t = v;
      if (t < 0) t = 0;
      if (t > H - 1) t = H - 1;
      return t;
   endfunction

   // Completed source rows needed before window row k may start:
   // rows 0..min(k+2, H-1).
   function automatic int rows_needed(input int k);
      int n;
      n = k + 3;
      if (n > H) n = H;
      return n;
   endfunction

   // ---------------------------------------------------------------- state
   logic [1:0]    state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    rep_q, rep_d;
   logic [RW-1:0] row_q, row_d;
   line_idx_t     line_k_q, line_k_d;    // ring slot holding source row k
   logic [RW-1:0] rel_q, rel_d;          // source rows released this frame
   logic [CW-1:0] wr_col_q, wr_col_d;
   logic [RW-1:0] wr_row_q, wr_row_d;    // completed source rows this frame
   line_idx_t     wr_line_q, wr_line_d;
   logic          in_ready_q, in_ready_d;
   logic          valid_q, valid_d;
   logic [PW-1:0] win_q [WIN_DIM][WIN_DIM];
   logic [PW-1:0] win_d [WIN_DIM][WIN_DIM];

   // ---------------------------------------------------------------- datapath
   logic                 accept;
   logic                 xfer;
   logic                 frame_done;
   logic                 avail_cur;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic [AW-1:0]        wr_addr;
   logic [NUM_LINES-1:0] wr_en_vec;
   logic [PW-1:0]        rd_data_all [NUM_LINES];
   line_idx_t            line_sel [WIN_DIM];
   logic [PW-1:0]        col_data [WIN_DIM];

   assign accept     = in_valid && in_ready_q;
   assign xfer       = valid_q && bcci_req_ready;
   assign frame_done = (state_q == ST_ROW_END) && (rep_q == 2'd3) &&
                       (row_q == RW'(H - 1));
   assign avail_cur  = int'(wr_row_q) >= rows_needed(int'(row_q));
   assign wr_addr    = AW'(wr_col_q);

   always_comb begin
      for (int g = 0; g < NUM_LINES; g++) begin
         wr_en_vec[g] = accept && (wr_line_q == LINE_IDX_W'(g));
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      bicubic_line_mem #(
         .DATA_W (PW),
         .DEPTH  (W),
         .AW     (AW)
      ) u_line_mem (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (wr_en_vec[g]),
         .wr_addr (wr_addr),
         .wr_data (in_data),
         .rd_en   (rd_en),
         .rd_addr (rd_addr),
         .rd_data (rd_data_all[g])
      );
   end

   // Window row r reads source row clamp(k-1+r); its ring slot is the slot of
   // row k shifted by the (clamped) row distance.
   always_comb begin
      for (int r = 0; r < WIN_DIM; r++) begin
         line_sel[r] = ring_add(line_k_q, clamp_row(int'(row_q) - 1 + r) - int'(row_q));
         col_data[r] = rd_data_all[line_sel[r]];
      end
   end

   // ---------------------------------------------------------------- read FSM
   // The read data register always holds column clamp(j+2) while window j is
   // offered, so each transfer shifts it in and requests clamp(j+3).
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      col_d    = col_q;
      rep_d    = rep_q;
      row_d    = row_q;
      line_k_d = line_k_q;
      rel_d    = rel_q;
      valid_d  = valid_q;
      win_d    = win_q;
      rd_en    = 1'b0;
      rd_addr  = '0;

      case (state_q)
         ST_FILL: begin
            if (avail_cur) begin
               rd_en   = 1'b1;
               rd_addr = clamp_col(0);
               phase_d = 2'd1;
               state_d = ST_PRIME;
            end
         end

         ST_PRIME: begin
            case (phase_q)
               2'd0: begin
                  if (avail_cur) begin
                     rd_en   = 1'b1;
                     rd_addr = clamp_col(0);
                     phase_d = 2'd1;
                  end
               end
               2'd1: begin
                  // Columns -2, -1, 0 all clamp to column 0.
                  for (int r = 0; r < WIN_DIM; r++) begin
                     for (int c = 0; c < WIN_DIM - 1; c++) begin
                        win_d[r][c] = col_data[r];
                     end
                  end
                  rd_en   = 1'b1;
                  rd_addr = clamp_col(1);
                  phase_d = 2'd2;
               end
               default: begin
                  for (int r = 0; r < WIN_DIM; r++) begin
                     win_d[r][WIN_DIM-1] = col_data[r];
                  end
                  rd_en   = 1'b1;
                  rd_addr = clamp_col(2);
                  phase_d = 2'd0;
                  col_d   = '0;
                  valid_d = 1'b1;
                  state_d = ST_STREAM;
               end
            endcase
         end

         ST_STREAM: begin
            if (xfer) begin
               if (col_q == CW'(W)) begin
                  col_d   = '0;
                  valid_d = 1'b0;
                  state_d = ST_ROW_END;
               end else begin
                  for (int r = 0; r < WIN_DIM; r++) begin
                     for (int c = 0; c < WIN_DIM - 1; c++) begin
                        win_d[r][c] = win_q[r][c+1];
                     end
                     win_d[r][WIN_DIM-1] = col_data[r];
                  end
                  rd_en   = 1'b1;
                  rd_addr = clamp_col(int'(col_q) + 3);
                  col_d   = col_q + CW'(1);
               end
            end
         end

         default: begin // ST_ROW_END
            if (frame_done) begin
               rep_d    = '0;
               row_d    = '0;
               line_k_d = '0;
               rel_d    = '0;
               state_d  = ST_FILL;
            end else begin
               if (rep_q == 2'd3) begin
                  rep_d    = '0;
                  row_d    = row_q + RW'(1);
                  line_k_d = ring_add(line_k_q, 1);
                  // Row k-1 is the last use of the oldest row once k >= 1.
                  if (row_q != '0) rel_d = rel_q + RW'(1);
               end else begin
                  rep_d = rep_q + 2'd1;
               end
               state_d = ST_PRIME;
               // Issue the column-0 read here to hide one bubble when the
               // next row's lines are already complete.
               if (int'(wr_row_q) >= rows_needed(int'(row_d))) begin
                  rd_en   = 1'b1;
                  rd_addr = clamp_col(0);
                  phase_d = 2'd1;
               end else begin
                  phase_d = 2'd0;
               end
            end
         end
      endcase
   end

   // ---------------------------------------------------------------- write side
   always_comb begin
      wr_col_d  = wr_col_q;
      wr_row_d  = wr_row_q;
      wr_line_d = wr_line_q;
      if (frame_done) begin
         wr_col_d  = '0;
         wr_row_d  = '0;
         wr_line_d = '0;
      end else if (accept) begin
         if (wr_col_q == CW'(W - 1)) begin
            wr_col_d  = '0;
            wr_row_d  = wr_row_q + RW'(1);
            wr_line_d = ring_add(wr_line_q, 1);
         end else begin
            wr_col_d = wr_col_q + CW'(1);
         end
      end
      // A slot is free when the row it last held has been released.
      in_ready_d = (int'(wr_row_d) < H) &&
                   (int'(wr_row_d) < int'(rel_d) + NUM_LINES);
   end

   // ---------------------------------------------------------------- flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FILL;
         phase_q    <= '0;
         col_q      <= '0;
         rep_q      <= '0;
         row_q      <= '0;
         line_k_q   <= '0;
         rel_q      <= '0;
         wr_col_q   <= '0;
         wr_row_q   <= '0;
         wr_line_q  <= '0;
         in_ready_q <= 1'b0;
         valid_q    <= 1'b0;
         for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         col_q      <= col_d;
         rep_q      <= rep_d;
         row_q      <= row_d;
         line_k_q   <= line_k_d;
         rel_q      <= rel_d;
         wr_col_q   <= wr_col_d;
         wr_row_q   <= wr_row_d;
         wr_line_q  <= wr_line_d;
         in_ready_q <= in_ready_d;
         valid_q    <= valid_d;
         win_q      <= win_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign in_ready     = in_ready_q;
   assign bf_req_valid = valid_q;

   assign p1  = win_q[0][0];
   assign p2  = win_q[0][1];
   assign p3  = win_q[0][2];
   assign p4  = win_q[0][3];
   assign p5  = win_q[1][0];
   assign p6  = win_q[1][1];
   assign p7  = win_q[1][2];
   assign p8  = win_q[1][3];
   assign p9  = win_q[2][0];
   assign p10 = win_q[2][1];
   assign p11 = win_q[2][2];
   assign p12 = win_q[2][3];
   assign p13 = win_q[3][0];
   assign p14 = win_q[3][1];
   assign p15 = win_q[3][2];
   assign p16 = win_q[3][3];

endmodule

// File: tb/tb_bicubic_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_bicubic_window_buffer
//
// Bench for bicubic_window_buffer with W=8, H=4. A reference model computes
// every expected window directly from the source image array and the clamp
// rule; a hand-written table pins specific windows of the ramp image.
// -----------------------------------------------------------------------------
module tb_bicubic_window_buffer;

   localparam int CW_T = 8;
   localparam int W    = 8;
   localparam int H    = 4;
   localparam int NWIN = 4 * H * (W + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [CW_T-1:0] in_data;
   logic          bf_req_valid;
   logic          bcci_req_ready;
   logic [CW_T-1:0] p1, p2, p3, p4, p5, p6, p7, p8;
   logic [CW_T-1:0] p9, p10, p11, p12, p13, p14, p15, p16;

   bicubic_window_buffer #(
      .CHANNEL_WIDTH (CW_T),
      .BLOCK_SIZE    (W),
      .IMG_HEIGHT    (H)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .bf_req_valid   (bf_req_valid),
      .bcci_req_ready (bcci_req_ready),
      .p1 (p1), .p2 (p2), .p3 (p3), .p4 (p4),
      .p5 (p5), .p6 (p6), .p7 (p7), .p8 (p8),
      .p9 (p9), .p10 (p10), .p11 (p11), .p12 (p12),
      .p13 (p13), .p14 (p14), .p15 (p15), .p16 (p16)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- bench state
   typedef struct {
      int           k;
      int           j;
      logic [127:0] win;
   } vec_t;

   vec_t          tbl [5];
   logic [127:0]  exp_q [$];
   logic [127:0]  got [$];
   logic [7:0]    img [W*H];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            acc_cnt;
   int            drv_sent;
   bit            abort;
   int            mon_cnt;
   int            max_gap;
   int            stab_err;
   int            first_acc;
   bit            first_seen;

   // ---------------------------------------------------------------- checks
   task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic check_i(input string name, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic logic [127:0] model_win(input int k, input int j);
      logic [127:0] w;
      w = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            w[127 - 8*(4*r + c) -: 8] = img[clampi(k - 1 + r, 0, H - 1) * W + clampi(j - 2 + c, 0, W - 1)];
         end
      end
      return w;
   endfunction

   function automatic logic [127:0] mkw(input int v [16]);
      logic [127:0] w;
      for (int i = 0; i < 16; i++) begin
         w[127 - 8*i -: 8] = 8'(v[i]);
      end
      return w;
   endfunction

   function automatic logic [127:0] dut_win();
      return {p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16};
   endfunction

   task automatic build_expected();
      exp_q.delete();
      for (int k = 0; k < H; k++) begin
         for (int rep = 0; rep < 4; rep++) begin
            for (int j = 0; j <= W; j++) begin
               exp_q.push_back(model_win(k, j));
            end
         end
      end
   endtask

   task automatic load_ramp();
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            img[r*W + c] = 8'(16*r + c);
         end
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < W*H; i++) begin
         img[i] = 8'($urandom_range(0, 255));
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic drive_frame(input int duty);
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while (idx < W*H && !abort && cyc < 20000) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 99) < duty);
         in_data  = img[idx];
         if (in_valid && in_ready) begin
            idx++;
            acc_cnt++;
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      drv_sent = idx;
   endtask

   task automatic monitor(input int n_exp, input int ready_pct, input int stop_after);
      logic [127:0] cur;
      logic [127:0] held;
      bit           hold_prev;
      int           last;
      hold_prev  = 1'b0;
      held       = '0;
      last       = 0;
      mon_cnt    = 0;
      max_gap    = 0;
      stab_err   = 0;
      first_seen = 1'b0;
      first_acc  = 0;
      got.delete();
      for (int cyc = 0; cyc < 8000 && mon_cnt < n_exp; cyc++) begin
         @(negedge clk);
         bcci_req_ready = ($urandom_range(0, 99) < ready_pct);
         cur = dut_win();
         if (hold_prev && (!bf_req_valid || cur !== held)) stab_err++;
         if (bf_req_valid && !first_seen) begin
            first_seen = 1'b1;
            first_acc  = acc_cnt;
         end
         if (bf_req_valid && bcci_req_ready) begin
            got.push_back(cur);
            check_i("expected_window_available", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               check_w($sformatf("window_%0d", mon_cnt), cur, exp_q.pop_front());
            end
            if (mon_cnt > 0 && cyc - last > max_gap) max_gap = cyc - last;
            last = cyc;
            mon_cnt++;
            if (stop_after > 0 && mon_cnt == stop_after) break;
         end
         hold_prev = bf_req_valid && !bcci_req_ready;
         held      = cur;
      end
      check_i("window_count", mon_cnt, (stop_after > 0) ? stop_after : n_exp);
      abort = (stop_after > 0);
   endtask

   task automatic check_table(input string tag);
      int idx;
      for (int t = 0; t < 5; t++) begin
         idx = (tbl[t].k * 4) * (W + 1) + tbl[t].j;
         check_w($sformatf("%s_k%0d_j%0d", tag, tbl[t].k, tbl[t].j),
                 (idx < got.size()) ? got[idx] : 128'bx, tbl[t].win);
      end
   endtask

   task automatic check_idle(input string tag);
      int hits;
      hits = 0;
      bcci_req_ready = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (bf_req_valid) hits++;
      end
      check_i(tag, hits, 0);
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      int v [16];
      int same;

      v = '{0,0,0,1, 0,0,0,1, 16,16,16,17, 32,32,32,33};
      tbl[0].k = 0; tbl[0].j = 0; tbl[0].win = mkw(v);
      v = '{38,39,39,39, 54,55,55,55, 54,55,55,55, 54,55,55,55};
      tbl[1].k = 3; tbl[1].j = 8; tbl[1].win = mkw(v);
      v = '{2,3,4,5, 18,19,20,21, 34,35,36,37, 50,51,52,53};
      tbl[2].k = 1; tbl[2].j = 4; tbl[2].win = mkw(v);
      v = '{16,16,17,18, 32,32,33,34, 48,48,49,50, 48,48,49,50};
      tbl[3].k = 2; tbl[3].j = 1; tbl[3].win = mkw(v);
      v = '{6,7,7,7, 6,7,7,7, 22,23,23,23, 38,39,39,39};
      tbl[4].k = 0; tbl[4].j = 8; tbl[4].win = mkw(v);

      rst_n          = 1'b0;
      in_valid       = 1'b0;
      in_data        = '0;
      bcci_req_ready = 1'b0;
      abort          = 1'b0;
      acc_cnt        = 0;
      drv_sent       = 0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_i("reset_valid", int'(bf_req_valid), 0);
      check_i("reset_in_ready", int'(in_ready), 0);
      check_w("reset_window", dut_win(), '0);
      rst_n = 1'b1;
      check_i("in_ready_before_first_edge", int'(in_ready), 0);
      @(posedge clk);
      #1;
      check_i("in_ready_after_first_edge", int'(in_ready), 1);

      // Ramp image, ready always high.
      load_ramp();
      build_expected();
      fork
         drive_frame(100);
         monitor(NWIN, 100, 0);
      join
      check_i("t1_pixels_sent", drv_sent, W*H);
      check_table("t1");
      check_i("t1_max_gap_le_4", int'(max_gap <= 4), 1);
      check_i("t1_got_size", got.size(), NWIN);
      for (int k = 0; k < H; k++) begin
         same = 1;
         for (int rep = 1; rep < 4; rep++) begin
            for (int j = 0; j <= W; j++) begin
               if (got[(k*4 + rep)*(W+1) + j] !== got[(k*4)*(W+1) + j]) same = 0;
            end
         end
         check_i($sformatf("t1_replay_identical_k%0d", k), same, 1);
      end
      check_idle("t1_no_extra_windows");

      // Random image, random downstream ready.
      load_random();
      build_expected();
      fork
         drive_frame(100);
         monitor(NWIN, 50, 0);
      join
      check_i("t2_pixels_sent", drv_sent, W*H);
      check_i("t2_stable_while_stalled", stab_err, 0);
      check_idle("t2_no_extra_windows");

      // Ramp image, sparse input.
      load_ramp();
      build_expected();
      acc_cnt = 0;
      fork
         drive_frame(30);
         monitor(NWIN, 100, 0);
      join
      check_i("t3_pixels_sent", drv_sent, W*H);
      check_i("t3_first_valid_after_24", int'(first_acc >= 24), 1);
      check_w("t3_first_window", (got.size() > 0) ? got[0] : 128'bx, tbl[0].win);

      // Reset mid-frame after 50 windows, then a clean frame.
      build_expected();
      fork
         drive_frame(100);
         monitor(NWIN, 100, 50);
      join
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_i("t4_reset_valid", int'(bf_req_valid), 0);
      check_i("t4_reset_in_ready", int'(in_ready), 0);
      check_w("t4_reset_window", dut_win(), '0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      abort   = 1'b0;
      acc_cnt = 0;
      build_expected();
      fork
         drive_frame(100);
         monitor(NWIN, 60, 0);
      join
      check_i("t4_pixels_sent", drv_sent, W*H);
      check_table("t4");
      check_i("t4_stable_while_stalled", stab_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
